// File: rtl/mux_arbiter4.sv
// Four-requester round-robin arbiter driving a shared valid/ready output bus.
// A grant is held until the data is accepted, the request drops, or WAIT_LIMIT expires.

module mux4to1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [1:0]       sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  input  logic [WIDTH-1:0] d3_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = d0_i;
    unique case (sel_i)
      2'd0:    y_o = d0_i;
      2'd1:    y_o = d1_i;
      2'd2:    y_o = d2_i;
      2'd3:    y_o = d3_i;
      default: y_o = d0_i;
    endcase
  end

endmodule

module mux_arbiter4 #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       address,
  output logic [3:0]       ack,
  output logic             timeout
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  // Counter value seen in the last permitted waiting cycle of a grant.
  localparam logic [7:0] LimitM1 = 8'(WAIT_LIMIT - 1);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] address_q, address_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] ack_q, ack_d;
  logic       timeout_q, timeout_d;

  // First set request bit searching ptr, ptr+1, ... modulo 4.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    address_d = address_q;
    cnt_d     = cnt_q;
    ack_d     = 4'b0000;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          address_d = pick(req, ptr_q);
          cnt_d     = 8'd0;
          state_d   = StGrant;
        end
      end
      StGrant: begin
        if (!req[address_q]) begin
          // Abort beats out_ready and leaves the pointer alone.
          state_d = StIdle;
        end else if (out_ready) begin
          ack_d   = 4'b0001 << address_q;
          ptr_d   = address_q + 2'd1;
          state_d = StIdle;
        end else if (cnt_q == LimitM1) begin
          timeout_d = 1'b1;
          ptr_d     = address_q + 2'd1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= 2'd0;
      address_q <= 2'd0;
      cnt_q     <= 8'd0;
      ack_q     <= 4'b0000;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      address_q <= address_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
    end
  end

  mux4to1 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .sel_i(address_q),
    .d0_i (in0),
    .d1_i (in1),
    .d2_i (in2),
    .d3_i (in3),
    .y_o  (out)
  );

  assign out_valid = (state_q == StGrant);
  assign address   = address_q;
  assign ack       = ack_q;
  assign timeout   = timeout_q;

endmodule
